// File: rtl/axil_reg_bridge.sv
// AXI4-Lite slave that turns single-beat reads and writes into one-cycle register strobes
// on a simple word-addressed register port with a fixed one-cycle read latency.
module axil_reg_bridge #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int NUM_REGS       = 16
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [AXI_ADDR_WIDTH-1:0]     s_axil_awaddr,
    input  logic                          s_axil_awvalid,
    output logic                          s_axil_awready,
    input  logic [AXI_DATA_WIDTH-1:0]     s_axil_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0]   s_axil_wstrb,
    input  logic                          s_axil_wvalid,
    output logic                          s_axil_wready,
    output logic [1:0]                    s_axil_bresp,
    output logic                          s_axil_bvalid,
    input  logic                          s_axil_bready,
    input  logic [AXI_ADDR_WIDTH-1:0]     s_axil_araddr,
    input  logic                          s_axil_arvalid,
    output logic                          s_axil_arready,
    output logic [AXI_DATA_WIDTH-1:0]     s_axil_rdata,
    output logic [1:0]                    s_axil_rresp,
    output logic                          s_axil_rvalid,
    input  logic                          s_axil_rready,
    output logic                          reg_wr_en,
    output logic [AXI_ADDR_WIDTH-1:0]     reg_wr_addr,
    output logic [AXI_DATA_WIDTH-1:0]     reg_wr_data,
    output logic                          reg_rd_en,
    output logic [AXI_ADDR_WIDTH-1:0]     reg_rd_addr,
    input  logic [AXI_DATA_WIDTH-1:0]     reg_rd_data
);

    localparam int STRB_WIDTH = AXI_DATA_WIDTH / 8;
    localparam int ADDR_LSB   = $clog2(STRB_WIDTH);
    localparam logic [AXI_ADDR_WIDTH-1:0] NUM_REGS_W = AXI_ADDR_WIDTH'(NUM_REGS);

    typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_REQ, R_WAIT, R_RESP} r_state_t;

    // ---------------- write path ----------------
    w_state_t                  w_state_reg, w_state_next;
    logic                      aw_held_reg, aw_held_next;
    logic                      w_held_reg, w_held_next;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr_reg, aw_addr_next;
    logic [AXI_DATA_WIDTH-1:0] w_data_reg, w_data_next;
    logic [STRB_WIDTH-1:0]     w_strb_reg, w_strb_next;
    logic                      wr_ok_reg, wr_ok_next;
    logic [AXI_ADDR_WIDTH-1:0] wr_addr_reg, wr_addr_next;
    logic [AXI_DATA_WIDTH-1:0] wr_data_reg, wr_data_next;
    logic                      aw_hs, w_hs, b_hs;

    assign s_axil_awready = rstn && (w_state_reg == W_IDLE) && !aw_held_reg;
    assign s_axil_wready  = rstn && (w_state_reg == W_IDLE) && !w_held_reg;
    assign s_axil_bvalid  = rstn && (w_state_reg == W_RESP);
    assign s_axil_bresp   = (s_axil_bvalid && !wr_ok_reg) ? 2'b10 : 2'b00;
    assign reg_wr_en      = rstn && (w_state_reg == W_EXEC) && wr_ok_reg;
    assign reg_wr_addr    = wr_addr_reg;
    assign reg_wr_data    = wr_data_reg;

    assign aw_hs = s_axil_awvalid && s_axil_awready;
    assign w_hs  = s_axil_wvalid && s_axil_wready;
    assign b_hs  = s_axil_bvalid && s_axil_bready;

    always_comb begin
        w_state_next = w_state_reg;
        aw_held_next = aw_held_reg;
        w_held_next  = w_held_reg;
        aw_addr_next = aw_addr_reg;
        w_data_next  = w_data_reg;
        w_strb_next  = w_strb_reg;
        wr_ok_next   = wr_ok_reg;
        wr_addr_next = wr_addr_reg;
        wr_data_next = wr_data_reg;
        case (w_state_reg)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_held_next = 1'b1;
                    aw_addr_next = s_axil_awaddr;
                end
                if (w_hs) begin
                    w_held_next = 1'b1;
                    w_data_next = s_axil_wdata;
                    w_strb_next = s_axil_wstrb;
                end
                // Strobe outputs only change when a write is actually issued.
                if (aw_held_next && w_held_next) begin
                    wr_addr_next = aw_addr_next >> ADDR_LSB;
                    wr_data_next = w_data_next;
                    wr_ok_next   = (wr_addr_next < NUM_REGS_W) && (&w_strb_next);
                    w_state_next = W_EXEC;
                end
            end
            W_EXEC: w_state_next = W_RESP;
            W_RESP: begin
                if (b_hs) begin
                    aw_held_next = 1'b0;
                    w_held_next  = 1'b0;
                    w_state_next = W_IDLE;
                end
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            w_state_reg <= W_IDLE;
            aw_held_reg <= 1'b0;
            w_held_reg  <= 1'b0;
            aw_addr_reg <= '0;
            w_data_reg  <= '0;
            w_strb_reg  <= '0;
            wr_ok_reg   <= 1'b0;
            wr_addr_reg <= '0;
            wr_data_reg <= '0;
        end else begin
            w_state_reg <= w_state_next;
            aw_held_reg <= aw_held_next;
            w_held_reg  <= w_held_next;
            aw_addr_reg <= aw_addr_next;
            w_data_reg  <= w_data_next;
            w_strb_reg  <= w_strb_next;
            wr_ok_reg   <= wr_ok_next;
            wr_addr_reg <= wr_addr_next;
            wr_data_reg <= wr_data_next;
        end
    end

    // ---------------- read path ----------------
    r_state_t                  r_state_reg, r_state_next;
    logic                      rd_ok_reg, rd_ok_next;
    logic [AXI_ADDR_WIDTH-1:0] rd_addr_reg, rd_addr_next;
    logic [AXI_DATA_WIDTH-1:0] rdata_reg, rdata_next;
    logic [1:0]                rresp_reg, rresp_next;
    logic                      ar_hs, r_hs;

    assign s_axil_arready = rstn && (r_state_reg == R_IDLE);
    assign s_axil_rvalid  = rstn && (r_state_reg == R_RESP);
    assign s_axil_rdata   = rdata_reg;
    assign s_axil_rresp   = rresp_reg;
    assign reg_rd_en      = rstn && (r_state_reg == R_REQ) && rd_ok_reg;
    assign reg_rd_addr    = rd_addr_reg;

    assign ar_hs = s_axil_arvalid && s_axil_arready;
    assign r_hs  = s_axil_rvalid && s_axil_rready;

    always_comb begin
        r_state_next = r_state_reg;
        rd_ok_next   = rd_ok_reg;
        rd_addr_next = rd_addr_reg;
        rdata_next   = rdata_reg;
        rresp_next   = rresp_reg;
        case (r_state_reg)
            R_IDLE: begin
                if (ar_hs) begin
                    rd_addr_next = s_axil_araddr >> ADDR_LSB;
                    rd_ok_next   = (rd_addr_next < NUM_REGS_W);
                    r_state_next = R_REQ;
                end
            end
            R_REQ: r_state_next = R_WAIT;
            R_WAIT: begin
                // Register file answers exactly one cycle after the strobe.
                rdata_next   = rd_ok_reg ? reg_rd_data : '0;
                rresp_next   = rd_ok_reg ? 2'b00 : 2'b10;
                r_state_next = R_RESP;
            end
            R_RESP: begin
                if (r_hs) r_state_next = R_IDLE;
            end
            default: r_state_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state_reg <= R_IDLE;
            rd_ok_reg   <= 1'b0;
            rd_addr_reg <= '0;
            rdata_reg   <= '0;
            rresp_reg   <= 2'b00;
        end else begin
            r_state_reg <= r_state_next;
            rd_ok_reg   <= rd_ok_next;
            rd_addr_reg <= rd_addr_next;
            rdata_reg   <= rdata_next;
            rresp_reg   <= rresp_next;
        end
    end

endmodule

// File: tb/tb_axil_reg_bridge.sv
// Directed self-checking bench for axil_reg_bridge with a small register-file model
// answering reads one cycle after each strobe.
module tb_axil_reg_bridge;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] s_axil_awaddr;
    logic        s_axil_awvalid;
    logic        s_axil_awready;
    logic [31:0] s_axil_wdata;
    logic [3:0]  s_axil_wstrb;
    logic        s_axil_wvalid;
    logic        s_axil_wready;
    logic [1:0]  s_axil_bresp;
    logic        s_axil_bvalid;
    logic        s_axil_bready;
    logic [31:0] s_axil_araddr;
    logic        s_axil_arvalid;
    logic        s_axil_arready;
    logic [31:0] s_axil_rdata;
    logic [1:0]  s_axil_rresp;
    logic        s_axil_rvalid;
    logic        s_axil_rready;
    logic        reg_wr_en;
    logic [31:0] reg_wr_addr;
    logic [31:0] reg_wr_data;
    logic        reg_rd_en;
    logic [31:0] reg_rd_addr;
    logic [31:0] reg_rd_data;

    int cmps = 0;
    int errs = 0;
    int wr_count = 0;
    logic [31:0] regs [0:15];

    always #5 clk = ~clk;

    axil_reg_bridge #(
        .AXI_ADDR_WIDTH(32),
        .AXI_DATA_WIDTH(32),
        .NUM_REGS(16)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .s_axil_awaddr(s_axil_awaddr),
        .s_axil_awvalid(s_axil_awvalid),
        .s_axil_awready(s_axil_awready),
        .s_axil_wdata(s_axil_wdata),
        .s_axil_wstrb(s_axil_wstrb),
        .s_axil_wvalid(s_axil_wvalid),
        .s_axil_wready(s_axil_wready),
        .s_axil_bresp(s_axil_bresp),
        .s_axil_bvalid(s_axil_bvalid),
        .s_axil_bready(s_axil_bready),
        .s_axil_araddr(s_axil_araddr),
        .s_axil_arvalid(s_axil_arvalid),
        .s_axil_arready(s_axil_arready),
        .s_axil_rdata(s_axil_rdata),
        .s_axil_rresp(s_axil_rresp),
        .s_axil_rvalid(s_axil_rvalid),
        .s_axil_rready(s_axil_rready),
        .reg_wr_en(reg_wr_en),
        .reg_wr_addr(reg_wr_addr),
        .reg_wr_data(reg_wr_data),
        .reg_rd_en(reg_rd_en),
        .reg_rd_addr(reg_rd_addr),
        .reg_rd_data(reg_rd_data)
    );

    // Register file: preload i*0x101 (reg 3 = 0x1234); unstrobed reads return junk.
    always @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < 16; i++) regs[i] <= 32'(i) * 32'h101;
            regs[3] <= 32'h1234;
        end else if (reg_wr_en) begin
            regs[reg_wr_addr[3:0]] <= reg_wr_data;
        end
        reg_rd_data <= reg_rd_en ? regs[reg_rd_addr[3:0]] : 32'hBAD0BAD0;
        if (reg_wr_en) wr_count <= wr_count + 1;
    end

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic mid;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        repeat (3) cyc();
        mid();
        $display("reset asserted");
        cmps++; if (s_axil_awready !== 1'b0) begin errs++; $display("FAIL reset_awready: got %b want 0", s_axil_awready); end
        cmps++; if (s_axil_wready !== 1'b0) begin errs++; $display("FAIL reset_wready: got %b want 0", s_axil_wready); end
        cmps++; if (s_axil_arready !== 1'b0) begin errs++; $display("FAIL reset_arready: got %b want 0", s_axil_arready); end
        cmps++; if (s_axil_bvalid !== 1'b0) begin errs++; $display("FAIL reset_bvalid: got %b want 0", s_axil_bvalid); end
        cmps++; if (s_axil_rvalid !== 1'b0) begin errs++; $display("FAIL reset_rvalid: got %b want 0", s_axil_rvalid); end
        cmps++; if (reg_wr_en !== 1'b0) begin errs++; $display("FAIL reset_wr_en: got %b want 0", reg_wr_en); end
        cmps++; if (reg_rd_en !== 1'b0) begin errs++; $display("FAIL reset_rd_en: got %b want 0", reg_rd_en); end
        cmps++; if (s_axil_bresp !== 2'b00) begin errs++; $display("FAIL reset_bresp: got %b want 00", s_axil_bresp); end
        cmps++; if (s_axil_rresp !== 2'b00) begin errs++; $display("FAIL reset_rresp: got %b want 00", s_axil_rresp); end
        cmps++; if (s_axil_rdata !== 32'h0) begin errs++; $display("FAIL reset_rdata: got %h want 0", s_axil_rdata); end
        cmps++; if (reg_wr_addr !== 32'h0) begin errs++; $display("FAIL reset_wr_addr: got %h want 0", reg_wr_addr); end
        cmps++; if (reg_wr_data !== 32'h0) begin errs++; $display("FAIL reset_wr_data: got %h want 0", reg_wr_data); end
        cmps++; if (reg_rd_addr !== 32'h0) begin errs++; $display("FAIL reset_rd_addr: got %h want 0", reg_rd_addr); end
        cyc(); rstn = 1'b1;
        mid();
        $display("reset released");
        cmps++; if (s_axil_awready !== 1'b1) begin errs++; $display("FAIL release_awready: got %b want 1", s_axil_awready); end
        cmps++; if (s_axil_wready !== 1'b1) begin errs++; $display("FAIL release_wready: got %b want 1", s_axil_wready); end
        cmps++; if (s_axil_arready !== 1'b1) begin errs++; $display("FAIL release_arready: got %b want 1", s_axil_arready); end
    endtask

    task automatic test_write_same_cycle;
        int n0;
        cyc();
        s_axil_awaddr = 32'h08; s_axil_awvalid = 1'b1;
        s_axil_wdata = 32'hDEADBEEF; s_axil_wstrb = 4'hF; s_axil_wvalid = 1'b1;
        n0 = wr_count;
        mid();
        $display("write addr=0x08 data=0xdeadbeef strb=f (AW+W same cycle)");
        cmps++; if (s_axil_awready !== 1'b1) begin errs++; $display("FAIL wsc_awready: got %b want 1", s_axil_awready); end
        cmps++; if (s_axil_wready !== 1'b1) begin errs++; $display("FAIL wsc_wready: got %b want 1", s_axil_wready); end
        cyc(); s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
        mid();
        cmps++; if (reg_wr_en !== 1'b1) begin errs++; $display("FAIL wsc_wr_en: got %b want 1", reg_wr_en); end
        cmps++; if (reg_wr_addr !== 32'd2) begin errs++; $display("FAIL wsc_wr_addr: got %h want 2", reg_wr_addr); end
        cmps++; if (reg_wr_data !== 32'hDEADBEEF) begin errs++; $display("FAIL wsc_wr_data: got %h want deadbeef", reg_wr_data); end
        cmps++; if (s_axil_awready !== 1'b0) begin errs++; $display("FAIL wsc_exec_awready: got %b want 0", s_axil_awready); end
        cmps++; if (s_axil_bvalid !== 1'b0) begin errs++; $display("FAIL wsc_early_bvalid: got %b want 0", s_axil_bvalid); end
        cyc(); s_axil_bready = 1'b1;
        mid();
        cmps++; if (s_axil_bvalid !== 1'b1) begin errs++; $display("FAIL wsc_bvalid: got %b want 1", s_axil_bvalid); end
        cmps++; if (s_axil_bresp !== 2'b00) begin errs++; $display("FAIL wsc_bresp: got %b want 00", s_axil_bresp); end
        cyc(); s_axil_bready = 1'b0;
        mid();
        cmps++; if (s_axil_bvalid !== 1'b0) begin errs++; $display("FAIL wsc_bvalid_clear: got %b want 0", s_axil_bvalid); end
        cmps++; if (s_axil_awready !== 1'b1) begin errs++; $display("FAIL wsc_awready_back: got %b want 1", s_axil_awready); end
        cmps++; if (wr_count !== n0 + 1) begin errs++; $display("FAIL wsc_wr_count: got %0d want %0d", wr_count, n0 + 1); end
    endtask

    task automatic test_write_w_first;
        int n1;
        cyc();
        s_axil_wdata = 32'hCAFEF00D; s_axil_wstrb = 4'hF; s_axil_wvalid = 1'b1;
        mid();
        $display("write data=0xcafef00d first, addr=0x3c three cycles later");
        cmps++; if (s_axil_wready !== 1'b1) begin errs++; $display("FAIL wf_wready: got %b want 1", s_axil_wready); end
        cyc(); s_axil_wvalid = 1'b0;
        mid();
        cmps++; if (s_axil_wready !== 1'b0) begin errs++; $display("FAIL wf_wready_held: got %b want 0", s_axil_wready); end
        cmps++; if (s_axil_awready !== 1'b1) begin errs++; $display("FAIL wf_awready_open: got %b want 1", s_axil_awready); end
        cyc();
        mid();
        cmps++; if (reg_wr_en !== 1'b0) begin errs++; $display("FAIL wf_early_wr_en: got %b want 0", reg_wr_en); end
        cyc(); s_axil_awaddr = 32'h3C; s_axil_awvalid = 1'b1;
        mid();
        cmps++; if (s_axil_awready !== 1'b1) begin errs++; $display("FAIL wf_awready: got %b want 1", s_axil_awready); end
        cyc(); s_axil_awvalid = 1'b0;
        mid();
        n1 = wr_count;
        cmps++; if (reg_wr_en !== 1'b1) begin errs++; $display("FAIL wf_wr_en: got %b want 1", reg_wr_en); end
        cmps++; if (reg_wr_addr !== 32'd15) begin errs++; $display("FAIL wf_wr_addr: got %h want f", reg_wr_addr); end
        cmps++; if (reg_wr_data !== 32'hCAFEF00D) begin errs++; $display("FAIL wf_wr_data: got %h want cafef00d", reg_wr_data); end
        for (int k = 0; k < 5; k++) begin
            cyc();
            mid();
            cmps++; if (s_axil_bvalid !== 1'b1) begin errs++; $display("FAIL wf_bvalid_hold%0d: got %b want 1", k, s_axil_bvalid); end
            cmps++; if (reg_wr_en !== 1'b0) begin errs++; $display("FAIL wf_no_rewrite%0d: got %b want 0", k, reg_wr_en); end
        end
        cmps++; if (wr_count !== n1 + 1) begin errs++; $display("FAIL wf_wr_count: got %0d want %0d", wr_count, n1 + 1); end
        cyc(); s_axil_bready = 1'b1;
        mid();
        cmps++; if (s_axil_bresp !== 2'b00) begin errs++; $display("FAIL wf_bresp: got %b want 00", s_axil_bresp); end
        cyc(); s_axil_bready = 1'b0;
        mid();
        cmps++; if (s_axil_bvalid !== 1'b0) begin errs++; $display("FAIL wf_bvalid_clear: got %b want 0", s_axil_bvalid); end
    endtask

    task automatic test_errors;
        logic [31:0] addrs [2] = '{32'h40, 32'h04};
        logic [3:0]  strbs [2] = '{4'hF, 4'h3};
        int n0;
        for (int k = 0; k < 2; k++) begin
            n0 = wr_count;
            cyc();
            s_axil_awaddr = addrs[k]; s_axil_awvalid = 1'b1;
            s_axil_wdata = 32'hFFFF0000; s_axil_wstrb = strbs[k]; s_axil_wvalid = 1'b1;
            mid();
            $display("bad write addr=0x%h strb=%h", addrs[k], strbs[k]);
            cyc(); s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
            mid();
            cmps++; if (reg_wr_en !== 1'b0) begin errs++; $display("FAIL err%0d_wr_en: got %b want 0", k, reg_wr_en); end
            cyc(); s_axil_bready = 1'b1;
            mid();
            cmps++; if (s_axil_bvalid !== 1'b1) begin errs++; $display("FAIL err%0d_bvalid: got %b want 1", k, s_axil_bvalid); end
            cmps++; if (s_axil_bresp !== 2'b10) begin errs++; $display("FAIL err%0d_bresp: got %b want 10", k, s_axil_bresp); end
            cyc(); s_axil_bready = 1'b0;
            mid();
            cmps++; if (wr_count !== n0) begin errs++; $display("FAIL err%0d_wr_count: got %0d want %0d", k, wr_count, n0); end
        end
        cyc(); s_axil_araddr = 32'h40; s_axil_arvalid = 1'b1;
        mid();
        $display("bad read addr=0x40");
        cyc(); s_axil_arvalid = 1'b0;
        mid();
        cmps++; if (reg_rd_en !== 1'b0) begin errs++; $display("FAIL errrd_rd_en: got %b want 0", reg_rd_en); end
        cyc();
        mid();
        cyc(); s_axil_rready = 1'b1;
        mid();
        cmps++; if (s_axil_rvalid !== 1'b1) begin errs++; $display("FAIL errrd_rvalid: got %b want 1", s_axil_rvalid); end
        cmps++; if (s_axil_rdata !== 32'h0) begin errs++; $display("FAIL errrd_rdata: got %h want 0", s_axil_rdata); end
        cmps++; if (s_axil_rresp !== 2'b10) begin errs++; $display("FAIL errrd_rresp: got %b want 10", s_axil_rresp); end
        cyc(); s_axil_rready = 1'b0;
        mid();
        cmps++; if (s_axil_rvalid !== 1'b0) begin errs++; $display("FAIL errrd_rvalid_clear: got %b want 0", s_axil_rvalid); end
    endtask

    task automatic test_read;
        logic [31:0] addrs [4] = '{32'h0C, 32'h08, 32'h3E, 32'h04};
        logic [31:0] words [4] = '{32'd3, 32'd2, 32'd15, 32'd1};
        logic [31:0] datas [4] = '{32'h1234, 32'hDEADBEEF, 32'hCAFEF00D, 32'h101};
        for (int k = 0; k < 4; k++) begin
            cyc(); s_axil_araddr = addrs[k]; s_axil_arvalid = 1'b1;
            mid();
            $display("read addr=0x%h expect 0x%h", addrs[k], datas[k]);
            cmps++; if (s_axil_arready !== 1'b1) begin errs++; $display("FAIL rd%0d_arready: got %b want 1", k, s_axil_arready); end
            cyc(); s_axil_arvalid = 1'b0;
            mid();
            cmps++; if (reg_rd_en !== 1'b1) begin errs++; $display("FAIL rd%0d_rd_en: got %b want 1", k, reg_rd_en); end
            cmps++; if (reg_rd_addr !== words[k]) begin errs++; $display("FAIL rd%0d_rd_addr: got %h want %h", k, reg_rd_addr, words[k]); end
            cyc();
            mid();
            cmps++; if (s_axil_rvalid !== 1'b0) begin errs++; $display("FAIL rd%0d_early_rvalid: got %b want 0", k, s_axil_rvalid); end
            cyc();
            mid();
            cmps++; if (s_axil_rvalid !== 1'b1) begin errs++; $display("FAIL rd%0d_rvalid: got %b want 1", k, s_axil_rvalid); end
            cmps++; if (s_axil_rdata !== datas[k]) begin errs++; $display("FAIL rd%0d_rdata: got %h want %h", k, s_axil_rdata, datas[k]); end
            cmps++; if (s_axil_rresp !== 2'b00) begin errs++; $display("FAIL rd%0d_rresp: got %b want 00", k, s_axil_rresp); end
            cyc(); s_axil_rready = 1'b1;
            mid();
            cmps++; if (s_axil_rdata !== datas[k]) begin errs++; $display("FAIL rd%0d_rdata_stable: got %h want %h", k, s_axil_rdata, datas[k]); end
            cyc(); s_axil_rready = 1'b0;
            mid();
            cmps++; if (s_axil_rvalid !== 1'b0) begin errs++; $display("FAIL rd%0d_rvalid_clear: got %b want 0", k, s_axil_rvalid); end
        end
    endtask

    task automatic test_same_cycle_rw;
        cyc();
        s_axil_awaddr = 32'h14; s_axil_awvalid = 1'b1;
        s_axil_wdata = 32'h55AA55AA; s_axil_wstrb = 4'hF; s_axil_wvalid = 1'b1;
        s_axil_araddr = 32'h14; s_axil_arvalid = 1'b1;
        mid();
        $display("write+read addr=0x14 same cycle, read expects old 0x00000505");
        cyc(); s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0; s_axil_arvalid = 1'b0;
        mid();
        cmps++; if (reg_wr_en !== 1'b1) begin errs++; $display("FAIL rw_wr_en: got %b want 1", reg_wr_en); end
        cmps++; if (reg_rd_en !== 1'b1) begin errs++; $display("FAIL rw_rd_en: got %b want 1", reg_rd_en); end
        cmps++; if (reg_wr_addr !== 32'd5) begin errs++; $display("FAIL rw_wr_addr: got %h want 5", reg_wr_addr); end
        cmps++; if (reg_rd_addr !== 32'd5) begin errs++; $display("FAIL rw_rd_addr: got %h want 5", reg_rd_addr); end
        cyc(); s_axil_bready = 1'b1;
        mid();
        cmps++; if (s_axil_bvalid !== 1'b1) begin errs++; $display("FAIL rw_bvalid: got %b want 1", s_axil_bvalid); end
        cyc(); s_axil_bready = 1'b0; s_axil_rready = 1'b1;
        mid();
        cmps++; if (s_axil_rvalid !== 1'b1) begin errs++; $display("FAIL rw_rvalid: got %b want 1", s_axil_rvalid); end
        cmps++; if (s_axil_rdata !== 32'h505) begin errs++; $display("FAIL rw_rdata: got %h want 00000505", s_axil_rdata); end
        cyc(); s_axil_rready = 1'b0;
        mid();
        cmps++; if (s_axil_rvalid !== 1'b0) begin errs++; $display("FAIL rw_rvalid_clear: got %b want 0", s_axil_rvalid); end
    endtask

    task automatic test_reset_midflight;
        cyc();
        s_axil_awaddr = 32'h00; s_axil_awvalid = 1'b1;
        s_axil_wdata = 32'h1; s_axil_wstrb = 4'hF; s_axil_wvalid = 1'b1;
        mid();
        $display("write addr=0x00 and read addr=0x1c interrupted by reset");
        cyc(); s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
        s_axil_araddr = 32'h1C; s_axil_arvalid = 1'b1;
        mid();
        cmps++; if (reg_wr_en !== 1'b1) begin errs++; $display("FAIL mid_wr_en: got %b want 1", reg_wr_en); end
        cyc(); s_axil_arvalid = 1'b0; rstn = 1'b0;
        mid();
        cyc();
        mid();
        cmps++; if (s_axil_bvalid !== 1'b0) begin errs++; $display("FAIL mid_bvalid: got %b want 0", s_axil_bvalid); end
        cmps++; if (s_axil_rvalid !== 1'b0) begin errs++; $display("FAIL mid_rvalid: got %b want 0", s_axil_rvalid); end
        cmps++; if (reg_rd_en !== 1'b0) begin errs++; $display("FAIL mid_rd_en: got %b want 0", reg_rd_en); end
        cmps++; if (s_axil_arready !== 1'b0) begin errs++; $display("FAIL mid_arready: got %b want 0", s_axil_arready); end
        cmps++; if (reg_wr_addr !== 32'h0) begin errs++; $display("FAIL mid_wr_addr: got %h want 0", reg_wr_addr); end
        cmps++; if (reg_rd_addr !== 32'h0) begin errs++; $display("FAIL mid_rd_addr: got %h want 0", reg_rd_addr); end
        cyc(); rstn = 1'b1;
        mid();
        cmps++; if (s_axil_awready !== 1'b1) begin errs++; $display("FAIL mid_awready: got %b want 1", s_axil_awready); end
        cmps++; if (s_axil_wready !== 1'b1) begin errs++; $display("FAIL mid_wready: got %b want 1", s_axil_wready); end
        cmps++; if (s_axil_arready !== 1'b1) begin errs++; $display("FAIL mid_arready_back: got %b want 1", s_axil_arready); end
        cyc();
        mid();
        cmps++; if (s_axil_bvalid !== 1'b0) begin errs++; $display("FAIL mid_dropped_b: got %b want 0", s_axil_bvalid); end
        cmps++; if (s_axil_rvalid !== 1'b0) begin errs++; $display("FAIL mid_dropped_r: got %b want 0", s_axil_rvalid); end
        cyc();
        s_axil_awaddr = 32'h10; s_axil_awvalid = 1'b1;
        s_axil_wdata = 32'h44444444; s_axil_wstrb = 4'hF; s_axil_wvalid = 1'b1;
        mid();
        $display("write addr=0x10 data=0x44444444 after reset");
        cyc(); s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
        mid();
        cmps++; if (reg_wr_en !== 1'b1) begin errs++; $display("FAIL post_wr_en: got %b want 1", reg_wr_en); end
        cmps++; if (reg_wr_addr !== 32'd4) begin errs++; $display("FAIL post_wr_addr: got %h want 4", reg_wr_addr); end
        cmps++; if (reg_wr_data !== 32'h44444444) begin errs++; $display("FAIL post_wr_data: got %h want 44444444", reg_wr_data); end
        cyc(); s_axil_bready = 1'b1;
        mid();
        cmps++; if (s_axil_bvalid !== 1'b1) begin errs++; $display("FAIL post_bvalid: got %b want 1", s_axil_bvalid); end
        cmps++; if (s_axil_bresp !== 2'b00) begin errs++; $display("FAIL post_bresp: got %b want 00", s_axil_bresp); end
        cyc(); s_axil_bready = 1'b0;
        mid();
        cmps++; if (s_axil_bvalid !== 1'b0) begin errs++; $display("FAIL post_bvalid_clear: got %b want 0", s_axil_bvalid); end
    endtask

    initial begin
        rstn = 1'b0;
        s_axil_awaddr = '0; s_axil_awvalid = 1'b0;
        s_axil_wdata = '0; s_axil_wstrb = '0; s_axil_wvalid = 1'b0;
        s_axil_bready = 1'b0;
        s_axil_araddr = '0; s_axil_arvalid = 1'b0;
        s_axil_rready = 1'b0;
        test_reset();
        test_write_same_cycle();
        test_write_w_first();
        test_errors();
        test_read();
        test_same_cycle_rw();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/axil_reg_bridge.md
AXIL_REG_BRIDGE -- requirements
Module: axil_reg_bridge

Interface
REQ-001 SHALL have parameter AXI_ADDR_WIDTH, default 32, AXI-Lite and register-port address width.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 32, data width; byte lanes = AXI_DATA_WIDTH/8.
REQ-003 SHALL have parameter NUM_REGS, default 16, number of legal word registers.
REQ-004 SHALL have port clk  in  1  clock; all logic on rising edge.
REQ-005 SHALL have port rstn  in  1  synchronous, active-low reset.
REQ-006 SHALL have port s_axil_awaddr  in  AXI_ADDR_WIDTH  write byte address.
REQ-007 SHALL have port s_axil_awvalid / s_axil_awready  in / out  1 each  AW handshake.
REQ-008 SHALL have port s_axil_wdata  in  AXI_DATA_WIDTH  write data.
REQ-009 SHALL have port s_axil_wstrb  in  AXI_DATA_WIDTH/8  write byte strobes.
REQ-010 SHALL have port s_axil_wvalid / s_axil_wready  in / out  1 each  W handshake.
REQ-011 SHALL have port s_axil_bresp  out  2  write response.
REQ-012 SHALL have port s_axil_bvalid / s_axil_bready  out / in  1 each  B handshake.
REQ-013 SHALL have port s_axil_araddr  in  AXI_ADDR_WIDTH  read byte address.
REQ-014 SHALL have port s_axil_arvalid / s_axil_arready  in / out  1 each  AR handshake.
REQ-015 SHALL have port s_axil_rdata  out  AXI_DATA_WIDTH  read data.
REQ-016 SHALL have port s_axil_rresp  out  2  read response.
REQ-017 SHALL have port s_axil_rvalid / s_axil_rready  out / in  1 each  R handshake.
REQ-018 SHALL have port reg_wr_en  out  1  one-cycle register write strobe.
REQ-019 SHALL have port reg_wr_addr  out  AXI_ADDR_WIDTH  word address (byte address >> log2(bytes)).
REQ-020 SHALL have port reg_wr_data  out  AXI_DATA_WIDTH  write data.
REQ-021 SHALL have port reg_rd_en  out  1  one-cycle register read strobe.
REQ-022 SHALL have port reg_rd_addr  out  AXI_ADDR_WIDTH  word address.
REQ-023 SHALL have port reg_rd_data  in  AXI_DATA_WIDTH  read data, valid exactly 1 cycle after reg_rd_en.

Function
REQ-024 Write path SHALL be FSM W_IDLE -> W_EXEC -> W_RESP -> W_IDLE; read path R_IDLE -> R_REQ -> R_WAIT -> R_RESP -> R_IDLE; the two paths independent.
REQ-025 In W_IDLE, awready SHALL be 1 while no AW is held and wready 1 while no W is held; AW and W accepted in either order or the same cycle, each latched.
REQ-026 When both AW and W are held (handshake cycle T), SHALL enter W_EXEC at T+1, with awready = wready = 0 until return to W_IDLE.
REQ-027 In W_EXEC, reg_wr_en SHALL be 1 for that single cycle iff word address < NUM_REGS and wstrb is all ones; otherwise reg_wr_en stays 0.
REQ-028 W_RESP (T+2) SHALL assert bvalid with bresp 2'b00 (legal) or 2'b10 SLVERR (out-of-range or partial wstrb); bvalid/bresp held until bready; on handshake clear held AW/W, go W_IDLE.
REQ-029 In R_IDLE, arready SHALL be 1; AR handshake at T latches address, enters R_REQ.
REQ-030 R_REQ (T+1) SHALL pulse reg_rd_en for one cycle iff word address < NUM_REGS.
REQ-031 R_WAIT (T+2) SHALL capture reg_rd_data into rdata (legal) or 0 (illegal), rresp 2'b00 / 2'b10.
REQ-032 R_RESP (T+3) SHALL assert rvalid holding rdata/rresp stable until rready; on handshake go R_IDLE.
REQ-033 reg_wr_addr/reg_wr_data/reg_rd_addr SHALL hold their last latched values between strobes.
REQ-034 Same-cycle read and write strobes SHALL both be issued; a read strobed in the same cycle as a write to the same address returns the pre-write value.
REQ-035 Byte-address low bits below word granularity SHALL be ignored.

Reset
REQ-036 While rstn = 0: both FSMs idle, held AW/W cleared, all ready/valid/strobe outputs 0, bresp/rresp/rdata/addresses/wr_data 0; in-flight transactions dropped without response.
REQ-037 First cycle after rstn = 1: awready, wready, arready = 1.

Verification
REQ-038 AW 0x08 + W 0xDEADBEEF, strb 0xF same cycle T -> reg_wr_en at T+1 with addr 2, data 0xDEADBEEF; bvalid, bresp 0 at T+2.
REQ-039 W at T, AW 0x3C at T+3 -> wready 0 from T+1, reg_wr_en at T+4 addr 15; bready held 0 for 5 cycles -> bvalid stays 1, no second write.
REQ-040 AR 0x0C at T, reg_rd_data = 0x1234 at T+2 -> reg_rd_en at T+1 addr 3; rvalid at T+3 with rdata 0x1234, rresp 0.
REQ-041 AW 0x40 (word 16) or wstrb 0x3 -> no reg_wr_en, bresp 2'b10; AR 0x40 -> no reg_rd_en, rdata 0, rresp 2'b10.
REQ-042 rstn low during W_RESP and R_REQ -> bvalid, rvalid, reg_rd_en 0 next cycle; after release, readies 1 and a fresh write completes normally.
